// File: rtl/exec_seq_pkg.sv
// exec_seq shared package: state codes, instruction fields, shift/ALU codes.
// Build option: EXEC_OVF_EN enables the V (signed overflow) status flag.
package exec_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_DECODE    = 3'd1;
  localparam state_t S_READ_A    = 3'd2;
  localparam state_t S_READ_B    = 3'd3;
  localparam state_t S_EXEC      = 3'd4;
  localparam state_t S_WRITE     = 3'd5;
  localparam state_t S_WRITE_IMM = 3'd6;
  localparam state_t S_DONE      = 3'd7;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_V = 0;

  function automatic logic [15:0] sext8(input logic [7:0] x);
    return {{8{x[7]}}, x};
  endfunction

endpackage

// File: rtl/exec_seq_if.sv
// exec_seq bus: start/done handshake plus register-file port signals.
// Build option: EXEC_OVF_EN (affects status[0] only).
interface exec_seq_if;
  logic        start;
  logic [15:0] instr;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic [2:0]  status;

  modport master (
    output start, instr, rf_data_out,
    input  busy, done, err, status,
    input  rf_readnum, rf_writenum,
    input  rf_write, rf_data_in
  );

  modport slave (
    input  start, instr, rf_data_out,
    output busy, done, err, status,
    output rf_readnum, rf_writenum,
    output rf_write, rf_data_in
  );
endinterface

// File: rtl/exec_seq_alu_shift.sv
// Combinational one-bit shifter on B feeding a 4-function ALU with flags.
// Build option: EXEC_OVF_EN computes V; otherwise V is tied to 0.
module alu_shift
  import exec_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  sh,
  input  logic [1:0]  op,
  output logic [15:0] y,
  output logic        z,
  output logic        n,
  output logic        v
);

  logic [15:0] bs;

  always_comb begin
    bs = b;
    unique case (sh)
      SH_NONE: bs = b;
      SH_LSL:  bs = {b[14:0], 1'b0};
      SH_LSR:  bs = {1'b0, b[15:1]};
      SH_ASR:  bs = {b[15], b[15:1]};
      default: bs = b;
    endcase
  end

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD:  y = a + bs;
      ALU_SUB:  y = a - bs;
      ALU_AND:  y = a & bs;
      ALU_NOTB: y = ~bs;
      default:  y = '0;
    endcase
  end

  assign z = (y == 16'd0);
  assign n = y[15];

`ifdef EXEC_OVF_EN
  // a - bs overflows when operand signs differ and result sign flips from a
  assign v = (a[15] ^ bs[15]) & (a[15] ^ y[15]);
`else
  assign v = 1'b0;
`endif

endmodule

// File: rtl/exec_seq.sv
// Multi-cycle execute sequencer driving an 8x16 register file.
// Build option: EXEC_OVF_EN enables the V bit of status.
module exec_seq
  import exec_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  exec_seq_if.slave bus
);

  state_t      state, nxt;
  logic [15:0] ir, a, b, c;
  logic [2:0]  st;

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;

  assign opc = ir[15:13];
  assign op  = ir[12:11];
  assign rn  = ir[10:8];
  assign rd  = ir[7:5];
  assign sh  = ir[4:3];
  assign rm  = ir[2:0];

  logic is_movi, is_movr, is_add;
  logic is_cmp, is_and, is_mvn, legal;

  assign is_movi = (opc == OPC_MOV) && (op == OP_MOVI);
  assign is_movr = (opc == OPC_MOV) && (op == OP_MOVR);
  assign is_add  = (opc == OPC_ALU) && (op == OP_ADD);
  assign is_cmp  = (opc == OPC_ALU) && (op == OP_CMP);
  assign is_and  = (opc == OPC_ALU) && (op == OP_AND);
  assign is_mvn  = (opc == OPC_ALU) && (op == OP_MVN);
  assign legal   = is_movi | is_movr | is_add
                 | is_cmp | is_and | is_mvn;

  logic [1:0]  alu_op;
  logic [15:0] a_op, alu_y;
  logic        fz, fn, fv;

  always_comb begin
    alu_op = ALU_ADD;
    unique case (1'b1)
      is_cmp:  alu_op = ALU_SUB;
      is_and:  alu_op = ALU_AND;
      is_mvn:  alu_op = ALU_NOTB;
      default: alu_op = ALU_ADD;
    endcase
  end

  // MOV reg never visits READ_A, so A is replaced by zero
  assign a_op = is_movr ? 16'd0 : a;

  alu_shift u_alu (
    .a  (a_op),
    .b  (b),
    .sh (sh),
    .op (alu_op),
    .y  (alu_y),
    .z  (fz),
    .n  (fn),
    .v  (fv)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   nxt = bus.start ? S_DECODE : S_IDLE;
      S_DECODE: begin
        unique case (1'b1)
          is_movi:                  nxt = S_WRITE_IMM;
          is_movr | is_mvn:         nxt = S_READ_B;
          is_add | is_cmp | is_and: nxt = S_READ_A;
          default:                  nxt = S_DONE;
        endcase
      end
      S_READ_A:    nxt = S_READ_B;
      S_READ_B:    nxt = S_EXEC;
      S_EXEC:      nxt = is_cmp ? S_DONE : S_WRITE;
      S_WRITE:     nxt = S_DONE;
      S_WRITE_IMM: nxt = S_DONE;
      S_DONE:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      st    <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && bus.start)
        ir <= bus.instr;
      if (state == S_READ_A)
        a <= bus.rf_data_out;
      if (state == S_READ_B)
        b <= bus.rf_data_out;
      if (state == S_EXEC) begin
        c <= alu_y;
        if (is_cmp) begin
          st[ST_Z] <= fz;
          st[ST_N] <= fn;
          st[ST_V] <= fv;
        end
      end
    end
  end

  logic wr_imm;
  assign wr_imm = (state == S_WRITE_IMM);

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.err         = (state == S_DONE) && !legal;
  assign bus.rf_readnum  = (state == S_READ_A) ? rn : rm;
  assign bus.rf_write    = (state == S_WRITE) || wr_imm;
  assign bus.rf_writenum = wr_imm ? rn : rd;
  assign bus.rf_data_in  = wr_imm ? sext8(ir[7:0]) : c;
  assign bus.status      = st;

endmodule
